rr_burst_scheduler: RTL and testbench
=====================================

Name: rr_burst_scheduler

Overview:
Round-robin scheduler that shares one slave-side streaming bus between NUM_MASTERS masters in the interconnect. It arbitrates among REQ bits and holds the grant for a whole burst of LEN+1 beats. It forwards the granted master's valid/ready/data beats to the slave and rotates priority past the winner once the last beat completes. It extends plain per-cycle round-robin arbitration to burst-atomic ownership of the shared resource.

Parameters:
NUM_MASTERS, 4, number of requesters; power of two, 2..8
DATA_W, 8, beat data width
LEN_W, 4, burst length field width; beats per burst = LEN+1 (1..2^LEN_W)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
REQ  in  NUM_MASTERS  per-master burst request, level
LEN  in  NUM_MASTERS*LEN_W  per-master burst length minus one; slice i = bits [i*LEN_W +: LEN_W]
M_DATA  in  NUM_MASTERS*DATA_W  per-master beat data; slice i as for LEN
M_VALID  in  NUM_MASTERS  per-master beat valid
M_READY  out  NUM_MASTERS  per-master beat ready; only the granted bit may be 1
GNT  out  NUM_MASTERS  one-hot grant, registered, held for the whole burst
S_DATA  out  DATA_W  data to the shared slave
S_VALID  out  1  beat valid to the slave
S_READY  in  1  slave ready
S_LAST  out  1  high with the final beat of the burst
BUSY  out  1  high while a burst is owned (GNT != 0)

Behaviour:
- Reset: synchronous; on a clk edge with reset=1, state=IDLE, GNT=0, beat counter=0, priority pointer=0. Combinational outputs then read S_VALID=0, S_LAST=0, M_READY=0, S_DATA=0, BUSY=0. Reset overrides any in-flight burst; no further beats are accepted.
- FSM has two states, IDLE and XFER.
- IDLE: if REQ!=0, search from index ptr upward with wrap (ptr, ptr+1, ..., ptr-1 mod N). The first set bit wins.
  - At the next edge: GNT=onehot(winner), counter=LEN[winner], state=XFER.
  - Latency: REQ sampled at edge k gives GNT high after edge k.
  - If REQ==0, stay in IDLE.
- XFER (GNT[g]=1):
  - S_VALID=M_VALID[g]; S_DATA=M_DATA[g]; M_READY[g]=S_READY; all other M_READY bits are 0. These paths are combinational.
  - Beat = S_VALID & S_READY. On each beat with counter!=0, counter decrements.
  - S_LAST = S_VALID & (counter==0).
  - On the beat with counter==0: GNT=0, ptr=(g+1) mod N (wraps N-1 to 0), state=IDLE.
- Every burst is followed by at least one IDLE arbitration cycle; there are no back-to-back grants.
- REQ or LEN changes during XFER are ignored. Dropping REQ mid-burst does not abort the burst. LEN is sampled only at grant.
- Stalls: if S_READY=0 or M_VALID[g]=0, there is no beat; counter, GNT and data mux hold. There is no timeout.
- Fairness: with all REQ bits held high, grant order is 0,1,2,...,N-1,0,...
- The pointer moves only on burst completion, never on an idle cycle.
- Outside XFER: S_VALID=0, S_DATA=0, S_LAST=0.
- Invariants: GNT is zero or one-hot; BUSY==(state==XFER)==|GNT.

Test Plan:
- Reset, then REQ=0001, LEN[0]=2, M_VALID[0]=1, S_READY=1, data A,B,C -> GNT=0001 one cycle after REQ; 3 beats A,B,C; S_LAST only on C; GNT=0000 after C; ptr=1.
- REQ=1111 held, all LEN=0, S_READY=1 -> GNT sequence 0001,0010,0100,1000,0001, each separated by one GNT=0000 IDLE cycle.
- Wrap: last grant to master 3, then REQ=1010 -> next GNT=0010. Then REQ=1010 again -> GNT=1000.
- Stall: burst LEN=3 with S_READY low for 3 cycles mid-burst -> S_DATA and GNT hold; exactly 4 beats total; M_READY[g] follows S_READY; other M_READY bits stay 0.
- Reset mid-burst: assert reset for 1 cycle after beat 2 of a 5-beat burst -> next cycle GNT=0, S_VALID=0, BUSY=0. Then REQ=0110 -> GNT=0010 (ptr reset to 0).
- REQ drop: master 2 deasserts REQ after grant with LEN=1 -> burst still completes 2 beats, then ptr=3.

Source files
------------

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: grants one master the shared slave stream for a whole
// LEN+1-beat burst, then rotates priority past the winner.
module rr_burst_scheduler #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        REQ,
    input  logic [NUM_MASTERS*LEN_W-1:0]  LEN,
    input  logic [NUM_MASTERS*DATA_W-1:0] M_DATA,
    input  logic [NUM_MASTERS-1:0]        M_VALID,
    output logic [NUM_MASTERS-1:0]        M_READY,
    output logic [NUM_MASTERS-1:0]        GNT,
    output logic [DATA_W-1:0]             S_DATA,
    output logic                          S_VALID,
    input  logic                          S_READY,
    output logic                          S_LAST,
    output logic                          BUSY
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] gnt, gnt_nxt;
    logic [LEN_W-1:0]       cnt, cnt_nxt;
    logic [PTR_W-1:0]       ptr, ptr_nxt;
    logic [PTR_W-1:0]       gidx, gidx_nxt;

    logic [LEN_W-1:0]       len_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]      data_arr [NUM_MASTERS];
    logic                   found;
    logic [PTR_W-1:0]       win;
    logic                   s_valid;
    logic                   beat;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            len_arr[i]  = LEN[i*LEN_W +: LEN_W];
            data_arr[i] = M_DATA[i*DATA_W +: DATA_W];
        end
    end

    // Rotating search starting at ptr; N is a power of two so the index wraps for free.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && REQ[ptr + PTR_W'(i)]) begin
                found = 1'b1;
                win   = ptr + PTR_W'(i);
            end
        end
    end

    assign s_valid = (state == XFER) && M_VALID[gidx];
    assign beat    = s_valid && S_READY;

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = XFER;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    cnt_nxt      = len_arr[win];
                    gidx_nxt     = win;
                end
            end
            XFER: begin
                if (beat) begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        ptr_nxt   = gidx + 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= '0;
            gidx  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            gidx  <= gidx_nxt;
        end
    end

    // Slave-side mux and the single ready return path are purely combinational.
    always_comb begin
        M_READY = '0;
        S_DATA  = '0;
        S_VALID = s_valid;
        S_LAST  = s_valid && (cnt == '0);
        if (state == XFER) begin
            M_READY[gidx] = S_READY;
            S_DATA        = data_arr[gidx];
        end
    end

    assign GNT  = gnt;
    assign BUSY = (state == XFER);

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Self-checking bench for rr_burst_scheduler: directed scenarios plus random traffic,
// all compared every cycle against a burst-level model (owner, beats remaining, pointer).
module tb_rr_burst_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic            busy;

    rr_burst_scheduler #(.NUM_MASTERS(N), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .REQ     (req),
        .LEN     (len),
        .M_DATA  (m_data),
        .M_VALID (m_valid),
        .M_READY (m_ready),
        .GNT     (gnt),
        .S_DATA  (s_data),
        .S_VALID (s_valid),
        .S_READY (s_ready),
        .S_LAST  (s_last),
        .BUSY    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the bus (-1 = nobody), beats still owed, next priority index.
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_len(input int i, input int v);
        len[i*LW +: LW] = LW'(v);
    endtask

    // Called with inputs settled after a falling edge: compare, clock, advance model.
    task automatic tick();
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_mrdy;
        logic [DW-1:0] e_data;
        logic          e_valid;
        logic          e_last;
        logic          e_busy;
        #2;
        e_gnt   = '0;
        e_mrdy  = '0;
        e_data  = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_busy  = 1'b0;
        if (m_owner >= 0) begin
            e_gnt   = N'(1 << m_owner);
            e_valid = m_valid[m_owner];
            e_data  = m_data[m_owner*DW +: DW];
            e_mrdy  = s_ready ? e_gnt : '0;
            e_last  = e_valid && (m_left == 1);
            e_busy  = 1'b1;
        end
        check("gnt",     gnt,     e_gnt);
        check("m_ready", m_ready, e_mrdy);
        check("s_valid", s_valid, e_valid);
        check("s_data",  s_data,  e_data);
        check("s_last",  s_last,  e_last);
        check("busy",    busy,    e_busy);
        @(posedge clk);
        if (reset) begin
            m_owner = -1;
            m_left  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_left  = int'(len[idx*LW +: LW]) + 1;
                end
            end
        end else if (m_valid[m_owner] && s_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] seq [9];
        logic         sched [7];
        int           beats;

        reset   = 1'b1;
        req     = '0;
        len     = '0;
        m_data  = '0;
        m_valid = '0;
        s_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",   gnt,     0);
        check("rst_busy",  busy,    0);
        check("rst_valid", s_valid, 0);
        check("rst_data",  s_data,  0);
        check("rst_mrdy",  m_ready, 0);
        reset = 1'b0;

        // Single 3-beat burst from master 0.
        req = 4'b0001; set_len(0, 2); m_valid = 4'b0001; s_ready = 1'b1; m_data[7:0] = 8'hA0;
        check("t1_pre_gnt", gnt, 0);
        tick();
        check("t1_gnt", gnt, 4'b0001);
        req = '0;
        #1 check("t1_a", s_data, 8'hA0);
        check("t1_a_last", s_last, 0);
        tick();
        m_data[7:0] = 8'hB0;
        #1 check("t1_b_last", s_last, 0);
        tick();
        m_data[7:0] = 8'hC0;
        #1 check("t1_c", s_data, 8'hC0);
        check("t1_c_last", s_last, 1);
        tick();
        check("t1_gnt_end", gnt, 0);
        check("t1_busy_end", busy, 0);
        check("t1_model_ptr", m_ptr, 1);

        // Fairness with all masters requesting single-beat bursts.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1111; len = '0; m_valid = 4'b1111; s_ready = 1'b1;
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t2_seq", gnt, seq[k]);
        end
        req = '0;
        tick();

        // Pointer wrap: grant master 3, then alternate 1 and 3.
        req = 4'b1000; tick();
        check("t3_gnt3", gnt, 4'b1000);
        req = '0; tick();
        req = 4'b1010; tick();
        check("t3_gnt1", gnt, 4'b0010);
        tick();
        check("t3_idle", gnt, 0);
        tick();
        check("t3_gnt3b", gnt, 4'b1000);
        req = '0; tick();

        // Stalled 4-beat burst from master 0.
        req = 4'b0001; set_len(0, 3); m_valid = 4'b0001; tick();
        req = '0;
        check("t4_gnt", gnt, 4'b0001);
        sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            s_ready = sched[k];
            m_data[7:0] = 8'h10 + 8'(beats);
            #1;
            check("t4_mrdy", m_ready, sched[k] ? 4'b0001 : 4'b0000);
            check("t4_data", s_data, 8'h10 + 8'(beats));
            check("t4_hold", gnt, 4'b0001);
            check("t4_last", s_last, (beats == 3) ? 1 : 0);
            if (sched[k]) beats++;
            tick();
        end
        check("t4_done", gnt, 0);
        s_ready = 1'b1;

        // Reset in the middle of a 5-beat burst from master 1.
        req = 4'b0010; set_len(1, 4); m_valid = 4'b0010; tick();
        req = '0; tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_gnt", gnt, 0);
        check("t5_busy", busy, 0);
        #1 check("t5_valid", s_valid, 0);
        req = 4'b0110; tick();
        check("t5_regnt", gnt, 4'b0010);
        req = '0;
        repeat (5) tick();
        check("t5_end", gnt, 0);

        // Master 2 drops REQ right after grant; burst still completes.
        req = 4'b0100; set_len(2, 1); m_valid = 4'b0100; tick();
        check("t6_gnt", gnt, 4'b0100);
        req = '0; tick();
        check("t6_mid", gnt, 4'b0100);
        tick();
        check("t6_end", gnt, 0);
        check("t6_model_ptr", m_ptr, 3);
        req = 4'b1111; m_valid = 4'b1111; set_len(3, 0); tick();
        check("t6_next", gnt, 4'b1000);
        req = '0; tick();

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            reset   = ($urandom_range(0, 199) == 0);
            req     = N'($urandom);
            len     = (N*LW)'($urandom);
            m_data  = (N*DW)'($urandom);
            for (int i = 0; i < N; i++) m_valid[i] = ($urandom_range(0, 3) != 0);
            s_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
